sw_input_loader: RTL and testbench

SW_INPUT_LOADER -- requirements
Module: sw_input_loader

---
 rtl/sw_input_loader.sv | 125 ++++++++++++
 tb/tb_sw_input_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_input_loader.sv
// Collects a frame of 2-bit query/database base pairs, packs them four per byte,
// then hands the packed bytes to a Smith-Waterman aligner with a one-cycle start pulse.
module sw_input_loader #(
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       base_valid,
  input  logic [1:0] base_query,
  input  logic [1:0] base_db,
  output logic       base_ready,
  input  logic       sw_ready,
  output logic       start,
  output logic [7:0] query_seq_in,
  output logic [7:0] database_seq_in,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int NB = 4 * WORDS;
  localparam int KW = $clog2(NB);
  localparam int JW = $clog2(WORDS);
  localparam int BW = 8 * WORDS;

  typedef enum logic [1:0] {FILL, WAIT_RDY, START, STREAM} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [JW-1:0]   j_q, j_d;
  logic [JW-1:0]   jn;
  logic [BW-1:0]   qbuf_q, qbuf_d;
  logic [BW-1:0]   dbuf_q, dbuf_d;
  logic            start_q, start_d;
  logic [7:0]      qout_q, qout_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      cnt_q, cnt_d;

  // Output registers are loaded from the state being entered, so start and
  // byte 0 appear exactly in the START cycle and are zero outside a stream.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    jn      = j_q + JW'(1);
    qbuf_d  = qbuf_q;
    dbuf_d  = dbuf_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    qout_d  = 8'd0;
    dout_d  = 8'd0;
    case (state_q)
      FILL: begin
        if (base_valid) begin
          qbuf_d[{k_q, 1'b0} +: 2] = base_query;
          dbuf_d[{k_q, 1'b0} +: 2] = base_db;
          if (k_q == KW'(NB - 1)) begin
            k_d     = '0;
            state_d = WAIT_RDY;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      WAIT_RDY: begin
        if (sw_ready) begin
          state_d = START;
          j_d     = '0;
          start_d = 1'b1;
          qout_d  = qbuf_q[7:0];
          dout_d  = dbuf_q[7:0];
        end
      end
      START: begin
        state_d = STREAM;
        j_d     = JW'(1);
        qout_d  = qbuf_q[15:8];
        dout_d  = dbuf_q[15:8];
      end
      STREAM: begin
        if (j_q == JW'(WORDS - 1)) begin
          state_d = FILL;
          j_d     = '0;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          j_d    = jn;
          qout_d = qbuf_q[{jn, 3'b000} +: 8];
          dout_d = dbuf_q[{jn, 3'b000} +: 8];
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      k_q     <= '0;
      j_q     <= '0;
      qbuf_q  <= '0;
      dbuf_q  <= '0;
      start_q <= 1'b0;
      qout_q  <= 8'd0;
      dout_q  <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      qbuf_q  <= qbuf_d;
      dbuf_q  <= dbuf_d;
      start_q <= start_d;
      qout_q  <= qout_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign base_ready      = (state_q == FILL);
  assign busy            = (state_q != FILL);
  assign start           = start_q;
  assign query_seq_in    = qout_q;
  assign database_seq_in = dout_q;
  assign frame_cnt       = cnt_q;

endmodule

// File: tb/tb_sw_input_loader.sv
// Directed bench for sw_input_loader with WORDS=4 (16 bases, 4 packed bytes per frame).
module tb_sw_input_loader;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       base_valid = 1'b0;
  logic [1:0] base_query = 2'd0;
  logic [1:0] base_db = 2'd0;
  logic       base_ready;
  logic       sw_ready = 1'b0;
  logic       start;
  logic [7:0] query_seq_in;
  logic [7:0] database_seq_in;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sw_input_loader #(.WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n), .base_valid(base_valid), .base_query(base_query),
    .base_db(base_db), .base_ready(base_ready), .sw_ready(sw_ready), .start(start),
    .query_seq_in(query_seq_in), .database_seq_in(database_seq_in), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Drives bases first..first+count-1; base k is taken from bits [2k+1:2k].
  // With gappy set, an idle cycle carrying inverted bases precedes each transfer.
  task automatic load_bases(input logic [31:0] qv, input logic [31:0] dv,
                            input int first, input int count, input bit gappy);
    for (int k = first; k < first + count; k++) begin
      if (gappy) begin
        base_valid = 1'b0;
        base_query = ~qv[2*k +: 2];
        base_db    = ~dv[2*k +: 2];
        @(posedge clk); #1;
      end
      base_valid = 1'b1;
      base_query = qv[2*k +: 2];
      base_db    = dv[2*k +: 2];
      @(posedge clk); #1;
    end
    base_valid = 1'b0;
    base_query = 2'd2;
    base_db    = 2'd1;
  endtask

  // Waits (bounded) for start, then records the four streamed bytes. Returns in the last byte cycle.
  task automatic capture(input bit drop, output logic [31:0] qb, output logic [31:0] db,
                         output int lat, output bit ok, output bit extra);
    lat = 0; ok = 1'b0; extra = 1'b0; qb = '0; db = '0;
    while (start !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (start === 1'b1) begin
      ok = 1'b1;
      qb[7:0] = query_seq_in;
      db[7:0] = database_seq_in;
      if (drop) sw_ready = 1'b0;
      for (int j = 1; j < W; j++) begin
        @(posedge clk); #1;
        qb[8*j +: 8] = query_seq_in;
        db[8*j +: 8] = database_seq_in;
        if (start !== 1'b0) extra = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    base_valid = 1'b1;
    sw_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    base_valid = 1'b0;
    n_cmp++; if ({start, query_seq_in, database_seq_in} !== 17'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=0", {start, query_seq_in, database_seq_in}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", frame_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (base_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", base_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] qb, db; int lat; bit ok, extra;
    sw_ready = 1'b1;
    // query bases 0,1,2,3 -> 0xE4 per byte; db all 3 -> 0xFF
    load_bases(32'hE4E4E4E4, 32'hFFFFFFFF, 0, 16, 1'b0);
    n_cmp++; if ({busy, base_ready, start} !== 3'b100) begin
      n_bad++; $display("FAIL basic_wait busy/ready/start got=%b want=100", {busy, base_ready, start}); end
    capture(1'b0, qb, db, lat, ok, extra);
    n_cmp++; if (ok !== 1'b1 || lat !== 1) begin
      n_bad++; $display("FAIL basic_latency ok=%b lat=%0d want ok=1 lat=1", ok, lat); end
    n_cmp++; if (qb !== 32'hE4E4E4E4) begin n_bad++; $display("FAIL basic_query got=%h want=e4e4e4e4", qb); end
    n_cmp++; if (db !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL basic_db got=%h want=ffffffff", db); end
    n_cmp++; if (extra !== 1'b0) begin n_bad++; $display("FAIL basic_start_once got=%b want=0", extra); end
    @(posedge clk); #1;
    n_cmp++; if ({busy, base_ready, start, query_seq_in} !== {3'b010, 8'd0}) begin
      n_bad++; $display("FAIL basic_back_fill got=%h want=%h", {busy, base_ready, start, query_seq_in}, {3'b010, 8'd0}); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL basic_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_gappy();
    logic [31:0] qb, db; int lat; bit ok, extra;
    load_bases(32'hE4E4E4E4, 32'hFFFFFFFF, 0, 16, 1'b1);
    capture(1'b0, qb, db, lat, ok, extra);
    n_cmp++; if (ok !== 1'b1 || lat !== 1) begin
      n_bad++; $display("FAIL gappy_latency ok=%b lat=%0d want ok=1 lat=1", ok, lat); end
    n_cmp++; if (qb !== 32'hE4E4E4E4) begin n_bad++; $display("FAIL gappy_query got=%h want=e4e4e4e4", qb); end
    n_cmp++; if (db !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL gappy_db got=%h want=ffffffff", db); end
    @(posedge clk); #1;
    n_cmp++; if (frame_cnt !== 8'd2) begin n_bad++; $display("FAIL gappy_cnt got=%0d want=2", frame_cnt); end
  endtask

  task automatic test_wait_ready();
    logic [31:0] qb, db; int lat; bit ok, extra; int bad_cycles;
    sw_ready = 1'b0;
    bad_cycles = 0;
    // query bases 1,0,3,2 repeating -> 0xB1; db base k/4 -> bytes 00,55,AA,FF
    load_bases(32'hB1B1B1B1, 32'hFFAA5500, 0, 16, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if ({busy, base_ready, start, query_seq_in, database_seq_in} !== {3'b100, 16'd0}) bad_cycles++;
      base_valid = 1'b1;
      base_query = 2'(i);
      base_db    = 2'(i + 1);
      @(posedge clk); #1;
    end
    n_cmp++; if (bad_cycles !== 0) begin
      n_bad++; $display("FAIL wait_hold bad_cycles=%0d want=0", bad_cycles); end
    base_valid = 1'b0;
    sw_ready = 1'b1;
    capture(1'b0, qb, db, lat, ok, extra);
    n_cmp++; if (ok !== 1'b1 || lat !== 1) begin
      n_bad++; $display("FAIL wait_start_latency ok=%b lat=%0d want ok=1 lat=1", ok, lat); end
    n_cmp++; if (qb !== 32'hB1B1B1B1) begin n_bad++; $display("FAIL wait_query got=%h want=b1b1b1b1", qb); end
    n_cmp++; if (db !== 32'hFFAA5500) begin n_bad++; $display("FAIL wait_db got=%h want=ffaa5500", db); end
    @(posedge clk); #1;
    n_cmp++; if (frame_cnt !== 8'd3) begin n_bad++; $display("FAIL wait_cnt got=%0d want=3", frame_cnt); end
  endtask

  task automatic test_drop_ready();
    logic [31:0] qb, db; int lat; bit ok, extra;
    sw_ready = 1'b1;
    load_bases(32'h01234567, 32'h89ABCDEF, 0, 16, 1'b0);
    capture(1'b1, qb, db, lat, ok, extra);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL drop_start ok=%b want=1", ok); end
    n_cmp++; if (qb !== 32'h01234567) begin n_bad++; $display("FAIL drop_query got=%h want=01234567", qb); end
    n_cmp++; if (db !== 32'h89ABCDEF) begin n_bad++; $display("FAIL drop_db got=%h want=89abcdef", db); end
    @(posedge clk); #1;
    n_cmp++; if ({busy, base_ready, frame_cnt} !== {2'b01, 8'd4}) begin
      n_bad++; $display("FAIL drop_end busy/ready/cnt got=%h want=%h", {busy, base_ready, frame_cnt}, {2'b01, 8'd4}); end
    sw_ready = 1'b1;
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] qb, db; int lat; bit ok, extra; int early;
    sw_ready = 1'b1;
    load_bases(32'hDEADBEEF, 32'h12345678, 0, 16, 1'b0);
    @(posedge clk); #1;      // START cycle
    @(posedge clk); #1;      // byte 1 cycle
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++; if ({start, query_seq_in, database_seq_in} !== 17'd0) begin
      n_bad++; $display("FAIL midrst_outputs got=%h want=0", {start, query_seq_in, database_seq_in}); end
    n_cmp++; if ({busy, base_ready, frame_cnt} !== {2'b01, 8'd0}) begin
      n_bad++; $display("FAIL midrst_state got=%h want=%h", {busy, base_ready, frame_cnt}, {2'b01, 8'd0}); end
    early = 0;
    load_bases(32'h5A5A5A5A, 32'hC3C3C3C3, 0, 15, 1'b0);
    repeat (5) begin
      if (start !== 1'b0 || busy !== 1'b0) early++;
      @(posedge clk); #1;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL midrst_no_early_start got=%0d want=0", early); end
    load_bases(32'h5A5A5A5A, 32'hC3C3C3C3, 15, 1, 1'b0);
    capture(1'b0, qb, db, lat, ok, extra);
    n_cmp++; if (ok !== 1'b1 || lat !== 1) begin
      n_bad++; $display("FAIL midrst_latency ok=%b lat=%0d want ok=1 lat=1", ok, lat); end
    n_cmp++; if (qb !== 32'h5A5A5A5A || db !== 32'hC3C3C3C3) begin
      n_bad++; $display("FAIL midrst_data got=%h/%h want=5a5a5a5a/c3c3c3c3", qb, db); end
    @(posedge clk); #1;
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL midrst_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qb, db, qv; logic [7:0] b; int lat; bit ok, extra;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sw_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b  = 8'(i * 37 + 5);
      qv = {4{b}};
      load_bases(qv, ~qv, 0, 16, 1'b0);
      capture(1'b0, qb, db, lat, ok, extra);
      if (ok !== 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL b2b_timeout frame=%0d start never seen", i);
        break;
      end
      n_cmp++; if (qb !== qv || db !== ~qv) begin
        n_bad++; $display("FAIL b2b_data frame=%0d got=%h/%h want=%h/%h", i, qb, db, qv, ~qv); end
      @(posedge clk); #1;
      n_cmp++; if (base_ready !== 1'b1 || frame_cnt !== 8'(i + 1)) begin
        n_bad++; $display("FAIL b2b_ready_cnt frame=%0d ready=%b cnt=%0d want ready=1 cnt=%0d",
                          i, base_ready, frame_cnt, 8'(i + 1)); end
    end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL b2b_wrap got=%0d want=0", frame_cnt); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_gappy();
    test_wait_ready();
    test_drop_ready();
    test_reset_mid_stream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
